// File: rtl/riscv_core_div_pkg.sv
// Shared types for the M-extension divider: operation codes, FSM states and
// the iteration counter sizing.
package riscv_core_div_pkg;

    localparam int DIV_XLEN_DEFAULT = 64;
    localparam int DIV_CNT_W        = $clog2(DIV_XLEN_DEFAULT + 1);

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    function automatic int div_cnt_width(input int xlen);
        return $clog2(xlen + 1);
    endfunction

endpackage

// File: rtl/riscv_core_divider_step.sv
// One restoring division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module riscv_core_divider_step
    import riscv_core_div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem,
    input  logic            next_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] new_rem,
    output logic            quo_bit
);

    logic [XLEN:0]   partial;
    logic [XLEN-1:0] diff;

    // rem < divisor on entry, so a successful subtraction always fits in XLEN bits
    always_comb begin
        partial = {rem, next_bit};
        quo_bit = (partial >= {1'b0, divisor});
        diff    = partial[XLEN-1:0] - divisor;
        new_rem = quo_bit ? diff : partial[XLEN-1:0];
    end

endmodule

// File: rtl/riscv_core_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU and their W forms.
// valid/ready: a transfer happens on a rising edge where both valid and ready are high.
module riscv_core_divider
    import riscv_core_div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_divider_valid,
    output logic            o_divider_ready,
    input  logic [1:0]      i_divider_op,
    input  logic            i_divider_word,
    input  logic [XLEN-1:0] i_divider_dividend,
    input  logic [XLEN-1:0] i_divider_divisor,
    input  logic            i_divider_flush,
    output logic            o_divider_valid,
    input  logic            i_divider_ready,
    output logic [XLEN-1:0] o_divider_result
);

    localparam int HALF  = XLEN / 2;
    localparam int CNT_W = div_cnt_width(XLEN);

    div_state_e      state, state_d;
    div_op_e         op_q;
    logic            word_q;
    logic            quo_neg_q, rem_neg_q;
    logic [XLEN-1:0] divisor_q, rem_q, quo_q, result_q;
    logic [CNT_W-1:0] cnt_q;

    logic            accept, signed_op, rem_op;
    logic [XLEN-1:0] dividend_ext, divisor_ext, dividend_mag, divisor_mag;
    logic            dividend_neg, divisor_neg;
    logic [XLEN-1:0] min_val, special_val, special_result;
    logic            div_zero, overflow;
    logic [XLEN-1:0] step_rem;
    logic            step_qbit;
    logic [XLEN-1:0] q_fix, r_fix, sel_fix, fix_result;

    function automatic logic [XLEN-1:0] word_fmt(input logic [XLEN-1:0] v, input logic w);
        return w ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
    endfunction

    // Operand conditioning at the accept edge
    always_comb begin
        signed_op = ~i_divider_op[0];
        rem_op    = i_divider_op[1];
        if (i_divider_word) begin
            dividend_ext = {{HALF{signed_op & i_divider_dividend[HALF-1]}}, i_divider_dividend[HALF-1:0]};
            divisor_ext  = {{HALF{signed_op & i_divider_divisor[HALF-1]}}, i_divider_divisor[HALF-1:0]};
            min_val      = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
        end else begin
            dividend_ext = i_divider_dividend;
            divisor_ext  = i_divider_divisor;
            min_val      = {1'b1, {(XLEN-1){1'b0}}};
        end
        dividend_neg = signed_op & dividend_ext[XLEN-1];
        divisor_neg  = signed_op & divisor_ext[XLEN-1];
        dividend_mag = dividend_neg ? -dividend_ext : dividend_ext;
        divisor_mag  = divisor_neg ? -divisor_ext : divisor_ext;
        div_zero     = (divisor_ext == '0);
        overflow     = signed_op & (dividend_ext == min_val) & (&divisor_ext);
        if (div_zero)
            special_val = rem_op ? dividend_ext : '1;
        else
            special_val = rem_op ? '0 : dividend_ext;
        special_result = word_fmt(special_val, i_divider_word);
        accept = i_divider_valid & (state == IDLE) & ~i_divider_flush;
    end

    riscv_core_divider_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_q),
        .next_bit (quo_q[XLEN-1]),
        .divisor  (divisor_q),
        .new_rem  (step_rem),
        .quo_bit  (step_qbit)
    );

    always_comb begin
        q_fix      = quo_neg_q ? -quo_q : quo_q;
        r_fix      = rem_neg_q ? -rem_q : rem_q;
        sel_fix    = ((op_q == REM) || (op_q == REMU)) ? r_fix : q_fix;
        fix_result = word_fmt(sel_fix, word_q);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d         = state;
        o_divider_ready = 1'b0;
        o_divider_valid = 1'b0;
        case (state)
            IDLE: begin
                o_divider_ready = 1'b1;
                if (accept) state_d = (div_zero | overflow) ? DONE : CALC;
            end
            CALC: if (cnt_q == CNT_W'(1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: begin
                o_divider_valid = 1'b1;
                if (i_divider_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (i_divider_flush) state_d = IDLE;
    end

    // Word operands sit in the upper half of the shifter so the MSB-first walk starts at bit HALF-1
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            op_q      <= DIV;
            word_q    <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else if (accept) begin
            op_q      <= div_op_e'(i_divider_op);
            word_q    <= i_divider_word;
            quo_neg_q <= dividend_neg ^ divisor_neg;
            rem_neg_q <= dividend_neg;
            divisor_q <= divisor_mag;
            rem_q     <= '0;
            quo_q     <= i_divider_word ? (dividend_mag << HALF) : dividend_mag;
            cnt_q     <= i_divider_word ? CNT_W'(HALF) : CNT_W'(XLEN);
            if (div_zero | overflow) result_q <= special_result;
        end else if (state == CALC) begin
            rem_q <= step_rem;
            quo_q <= {quo_q[XLEN-2:0], step_qbit};
            cnt_q <= cnt_q - CNT_W'(1);
        end else if (state == FIX) begin
            result_q <= fix_result;
        end
    end

    assign o_divider_result = result_q;

endmodule

// File: doc/riscv_core_divider.md
Name: riscv_core_divider

Overview:
Multi-cycle radix-2 restoring integer divider for the M-extension DIV/DIVU/REM/REMU and the RV64 word forms. It is the inverse-direction counterpart of the compressor-tree multiplier datapath. It sits beside the multiplier in the execute stage and talks to issue and writeback through valid/ready handshakes. One division is in flight at a time.

Parameters:
XLEN, 64, operand/result width; must be even. Word ops use XLEN/2.

Ports:
i_clk  input  1  clock, all state updates on the rising edge
i_rst  input  1  reset, asynchronous, active-high
i_divider_valid  input  1  request valid
o_divider_ready  output  1  divider can accept a request (high only in IDLE)
i_divider_op  input  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
i_divider_word  input  1  1 = W form (DIVW/DIVUW/REMW/REMUW)
i_divider_dividend  input  XLEN  rs1
i_divider_divisor  input  XLEN  rs2
i_divider_flush  input  1  pipeline kill; abort the current op
o_divider_valid  output  1  result valid
i_divider_ready  input  1  writeback accepts the result
o_divider_result  output  XLEN  quotient or remainder

Behaviour:
- Clock/reset: one clock i_clk; i_rst is asynchronous, active-high.
- Reset values: state=IDLE, o_divider_ready=1, o_divider_valid=0, o_divider_result=0, all internal registers 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - Accept on i_divider_valid & o_divider_ready & !i_divider_flush.
  - Latch the op and word flag.
  - Word ops take the low 32 bits of each operand: sign-extend for signed ops, zero-extend for unsigned.
  - Store operand magnitudes (absolute value for signed ops) and the result sign.
  - Load the iteration counter N = XLEN (or XLEN/2 for word ops).
  - Divisor == 0: go straight to DONE. Quotient = all ones; remainder = dividend (after word extension).
  - Signed overflow (dividend = most-negative, divisor = -1, at the effective width): go straight to DONE. Quotient = dividend; remainder = 0.
  - All other cases go to CALC.
- CALC, one restoring step per cycle:
  - partial remainder (XLEN+1 bits) = {rem, next dividend MSB} - divisor magnitude.
  - If the difference is non-negative: keep the difference and shift in quotient bit 1.
  - Otherwise: keep the shifted remainder and shift in 0.
  - Decrement the counter; after the N-th step go to FIX.
- FIX, one cycle:
  - Negate the quotient if the operand signs differ (signed ops only).
  - Negate the remainder if the dividend is negative (signed ops only).
  - Select quotient or remainder by op.
  - Word ops: sign-extend bit 31 of the selected value to XLEN.
  - Register into o_divider_result; go to DONE.
- DONE:
  - o_divider_valid=1; o_divider_result holds stable until i_divider_ready=1.
  - On that edge go to IDLE; o_divider_valid drops the same edge.
- Latency, accept edge to first o_divider_valid cycle:
  - N+2 cycles: 66 for 64-bit ops, 34 for word ops.
  - 1 cycle for the divide-by-zero and overflow cases.
- Throughput: the earliest new accept is the cycle after the result handshake. ready and valid are never high together.
- Flush:
  - In any state, the next state is IDLE.
  - o_divider_valid=0 next cycle; the result is discarded.
  - Flush in the same cycle as a request: the request is not accepted.
- Reset mid-operation: abandon immediately and return to the reset values above; no output pulse.
- Inputs are sampled only on the accept edge; changes during CALC have no effect.

Decomposition:
- Package riscv_core_div_pkg: div_op_e enum (DIV, DIVU, REM, REMU), div_state_e enum (IDLE, CALC, FIX, DONE), and the counter width localparam $clog2(XLEN+1).
- One natural sub-module: riscv_core_divider_step, the combinational single restoring iteration. Inputs: remainder, next bit, divisor. Outputs: new remainder, quotient bit.

Test Plan:
- DIVU 100/7, 64-bit -> result 14; o_divider_valid exactly 66 cycles after the accept. REMU same operands -> 2.
- DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD (-3). REM -7,2 -> 0xFFFF_FFFF_FFFF_FFFF (-1). REM 7,-2 -> 1.
- DIVU 5/0 -> 0xFFFF_FFFF_FFFF_FFFF; REMU 5,0 -> 5. REMW dividend 0x0000_0001_8000_0000, divisor 0 -> 0xFFFF_FFFF_8000_0000. All four have valid 1 cycle after accept.
- Overflow:
  - DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM same operands -> 0.
  - DIVW 0x8000_0000 / 0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000.
  - DIVUW 0xFFFF_FFFF_FFFF_FFF0 / 2 -> 0x0000_0000_7FFF_FFF8, latency 34.
- Handshake: hold i_divider_ready low for 5 cycles in DONE -> result stable and o_divider_ready=0 throughout. Assert i_divider_valid during CALC -> ignored.
- Abort:
  - Flush at CALC cycle 10 -> no valid pulse; o_divider_ready=1 next cycle; a following DIVU 9/3 returns 3.
  - i_rst pulse mid-CALC -> outputs return to their reset values asynchronously.
